// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with data-request tracking
//   clk, rst          clock, synchronous active-high reset
//   stage_req_i       per-stage local stall requests
//   flush_req_i       redirect request; flush_idx_i = last stage register to clear
//   bd_pending_i      delay slot of the redirecting branch not yet fetched
//   data_addr_ok_i    data request accepted; data_data_ok_i = data response returned
//   stall_o           hold for each stage input register (bit 0 = PC)
//   refresh_o         clear each stage input register to a bubble
//   out_full_o        outstanding data requests at MAX_OUT
//   drop_resp_o       current response belongs to a flushed request
//   stall_cycles_o    saturating count of cycles with the PC held
module pipe_ctrl #(
    parameter int STAGES  = 6,
    parameter int MAX_OUT = 2,
    parameter int CW      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STAGES-1:0]           stage_req_i,
    input  logic                        flush_req_i,
    input  logic [$clog2(STAGES)-1:0]   flush_idx_i,
    input  logic                        bd_pending_i,
    input  logic                        data_addr_ok_i,
    input  logic                        data_data_ok_i,
    output logic [STAGES-1:0]           stall_o,
    output logic [STAGES-1:0]           refresh_o,
    output logic                        out_full_o,
    output logic                        drop_resp_o,
    output logic [CW-1:0]               stall_cycles_o
);
    localparam int CNTW = $clog2(MAX_OUT + 1);
    typedef enum logic [1:0] {IDLE, BDWAIT, DRAIN, FLUSH} state_t;
    state_t                    state_q;
    logic [CNTW-1:0]           cnt_q, cnt_d, drop_q;
    logic [$clog2(STAGES)-1:0] idx_q;
    logic [CW-1:0]             sc_q;
    logic                      full, inc, dec, acc;
    logic [STAGES-1:0]         req, st, rf;
    always_comb begin
        full  = cnt_q == CNTW'(MAX_OUT);
        // addresses are never issued while draining, so ignore them there
        inc   = data_addr_ok_i && state_q != DRAIN;
        dec   = data_data_ok_i && cnt_q != '0;
        cnt_d = (inc && !dec && !full) ? cnt_q + 1'b1 : (dec && !inc) ? cnt_q - 1'b1 : cnt_q;
    end
    always_comb begin
        req = stage_req_i;
        // a full request window stalls the producer of the memory stage
        req[STAGES-3] = stage_req_i[STAGES-3] | full;
        acc = state_q == DRAIN || state_q == BDWAIT;
        st  = '0;
        rf  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc | req[k];
            st[k] = acc;
        end
        for (int k = 1; k < STAGES; k++) rf[k] = !st[k] && st[k-1];
        if (state_q == FLUSH) begin
            st[0] = 1'b0;
            for (int k = 1; k < STAGES; k++)
                if (k <= int'(idx_q)) begin
                    st[k] = 1'b0;
                    rf[k] = 1'b1;
                end
        end
        stall_o        = rst ? '0 : st;
        refresh_o      = rst ? '0 : rf;
        out_full_o     = !rst && full;
        drop_resp_o    = !rst && state_q == DRAIN && data_data_ok_i && drop_q != '0;
        stall_cycles_o = rst ? '0 : sc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= '0;
            idx_q   <= '0;
            sc_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            sc_q  <= (stall_o[0] && !(&sc_q)) ? sc_q + 1'b1 : sc_q;
            case (state_q)
                IDLE: if (flush_req_i) begin
                    idx_q   <= flush_idx_i;
                    drop_q  <= cnt_q;
                    state_q <= bd_pending_i ? BDWAIT : (cnt_q != '0) ? DRAIN : FLUSH;
                end
                BDWAIT: if (!bd_pending_i) state_q <= (cnt_q != '0) ? DRAIN : FLUSH;
                DRAIN: begin
                    if (data_data_ok_i && drop_q != '0) drop_q <= drop_q - 1'b1;
                    if (cnt_d == '0) state_q <= FLUSH;
                end
                FLUSH: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with directed cycle vectors
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] stage_req = '0;
    logic       flush_req = 1'b0;
    logic [2:0] flush_idx = '0;
    logic       bd_pending = 1'b0;
    logic       addr_ok = 1'b0;
    logic       data_ok = 1'b0;
    logic [5:0] stall, refresh;
    logic       out_full, drop_resp;
    logic [3:0] stall_cycles;

    typedef struct {
        string      n;
        logic [5:0] st;
        logic [5:0] rf;
        logic       f;
        logic       d;
        logic [3:0] sc;
    } exp_t;
    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    logic [3:0] sc_m = '0;
    bit   done = 1'b0;

    pipe_ctrl #(.STAGES(6), .MAX_OUT(2), .CW(4)) dut (
        .clk(clk), .rst(rst), .stage_req_i(stage_req), .flush_req_i(flush_req),
        .flush_idx_i(flush_idx), .bd_pending_i(bd_pending), .data_addr_ok_i(addr_ok),
        .data_data_ok_i(data_ok), .stall_o(stall), .refresh_o(refresh),
        .out_full_o(out_full), .drop_resp_o(drop_resp), .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    // one call = one clock cycle of inputs plus the outputs expected during it
    task automatic step(input string n, input logic r, input logic [5:0] sr, input logic fr,
                        input logic [2:0] fi, input logic bd, input logic ao, input logic dk,
                        input logic [5:0] es, input logic [5:0] erf, input logic ef, input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stage_req = sr; flush_req = fr; flush_idx = fi;
        bd_pending = bd; addr_ok = ao; data_ok = dk;
        e.n = n; e.st = es; e.rf = erf; e.f = ef; e.d = ed;
        e.sc = r ? 4'd0 : sc_m;
        sc_m = r ? 4'd0 : (es[0] && sc_m != 4'd15) ? sc_m + 4'd1 : sc_m;
        q.push_back(e);
    endtask

    task automatic chk(input string n, input string f, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s.%s: got %b, expected %b", n, f, act, req);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.n, "stall", stall, e.st);
            chk(e.n, "refresh", refresh, e.rf);
            chk(e.n, "out_full", {5'd0, out_full}, {5'd0, e.f});
            chk(e.n, "drop_resp", {5'd0, drop_resp}, {5'd0, e.d});
            chk(e.n, "stall_cycles", {2'd0, stall_cycles}, {2'd0, e.sc});
        end
    end

    initial begin
        //    name        rst sr         fr fi bd ao dk  stall      refresh    full drop
        step("rst_force", 1, 6'b111111, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("idle",      0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("req3",      0, 6'b001000, 0, 0, 0, 0, 0, 6'b001111, 6'b010000, 0, 0);
        step("req5",      0, 6'b100000, 0, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("req0",      0, 6'b000001, 0, 0, 0, 0, 0, 6'b000001, 6'b000010, 0, 0);
        step("addr1",     0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("addr2",     0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("full",      0, 6'b000000, 0, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0);
        step("addr_full", 0, 6'b000000, 0, 0, 0, 1, 0, 6'b001111, 6'b010000, 1, 0);
        step("resp1",     0, 6'b000000, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 1, 0);
        step("notfull",   0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("flush4",    0, 6'b000000, 1, 4, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("drain1",    0, 6'b000000, 0, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("drain2",    0, 6'b000000, 0, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("drop",      0, 6'b000000, 0, 0, 0, 0, 1, 6'b111111, 6'b000000, 0, 1);
        step("flush_i4",  0, 6'b100000, 0, 0, 0, 0, 0, 6'b100000, 6'b011110, 0, 0);
        step("idle2",     0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("flush_bd",  0, 6'b000000, 1, 2, 1, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("bdwait1",   0, 6'b000000, 1, 5, 1, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("bdwait2",   0, 6'b000000, 0, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("flush_i2",  0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000110, 0, 0);
        step("idle3",     0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("flush1",    0, 6'b000000, 1, 1, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("flush_i1",  0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000010, 0, 0);
        step("idle4",     0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("addr_a",    0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("flush3",    0, 6'b000000, 1, 3, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("drain_r",   0, 6'b000000, 0, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0);
        step("rst_drain", 1, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        step("resp_at0",  0, 6'b000000, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 0);
        step("addr_b",    0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("addr_c",    0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("full2",     0, 6'b000000, 0, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0);
        step("both_hold", 0, 6'b000000, 0, 0, 0, 1, 1, 6'b001111, 6'b010000, 1, 0);
        step("resp_b",    0, 6'b000000, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 1, 0);
        step("resp_c",    0, 6'b000000, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 0);
        step("resp_x",    0, 6'b000000, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 0);
        step("addr_d",    0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("addr_e",    0, 6'b000000, 0, 0, 0, 1, 0, 6'b000000, 6'b000000, 0, 0);
        step("full3",     0, 6'b000000, 0, 0, 0, 0, 1, 6'b001111, 6'b010000, 1, 0);
        step("resp_e",    0, 6'b000000, 0, 0, 0, 0, 1, 6'b000000, 6'b000000, 0, 0);
        for (int i = 0; i < 20; i++)
            step("sat", 0, 6'b000001, 0, 0, 0, 0, 0, 6'b000001, 6'b000010, 0, 0);
        step("sat_end",   0, 6'b000000, 0, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0);
        repeat (3) @(posedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
